// File: rtl/riscv_test_monitor_if.sv
// rtl/riscv_test_monitor_if.sv - register-file write-back snoop bus seen by the end-of-test monitor
interface riscv_test_monitor_if #(
  parameter int DATA_W = 32
);

  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              retire;

  // Core side drives the write-back port and the retire pulse.
  modport master (
    output wb_we,
    output wb_addr,
    output wb_data,
    output retire
  );

  // Monitor side only observes.
  modport slave (
    input wb_we,
    input wb_addr,
    input wb_data,
    input retire
  );

endinterface

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - end-of-test monitor snooping x3/x26/x27 write-back; optional RISCV_TEST_MONITOR_RETIRE_EN adds retire counting
module riscv_test_monitor #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_test_monitor_if.slave   wb,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [DATA_W-1:0]     fail_testnum,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  // Last cycle_cnt value seen in RUN before the watchdog fires.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

  state_t state_q, state_d;

  logic [DATA_W-1:0] x3_q, x26_q, x27_q;
  logic [DATA_W-1:0] x3_nxt, x26_nxt, x27_nxt;
  logic              wr_x3, wr_x26, wr_x27;
  logic              end_req;
  logic              wd_hit;
  logic              cnt_en;

  logic              done_d, pass_d, timeout_d;
  logic [DATA_W-1:0] fail_testnum_d;

  // Write decode; x0 and every other index fall through untouched.
  assign wr_x3  = wb.wb_we && (wb.wb_addr == 5'd3);
  assign wr_x26 = wb.wb_we && (wb.wb_addr == 5'd26);
  assign wr_x27 = wb.wb_we && (wb.wb_addr == 5'd27);

  // Shadow values as they will be after this edge, so same-edge writes
  // are visible to the verdict logic.
  assign x3_nxt  = wr_x3  ? wb.wb_data : x3_q;
  assign x26_nxt = wr_x26 ? wb.wb_data : x26_q;
  assign x27_nxt = wr_x27 ? wb.wb_data : x27_q;

  // Only a write of exactly 1 to x26 ends the test.
  assign end_req = wr_x26 && (x26_nxt == ONE);

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == WD_LAST);
  assign cnt_en = (state_q == S_RUN) || (state_q == S_CHECK);

  // Shadow registers track write-back in every state, terminal ones included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x3_q  <= '0;
      x26_q <= '0;
      x27_q <= '0;
    end else begin
      x3_q  <= x3_nxt;
      x26_q <= x26_nxt;
      x27_q <= x27_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next verdict; verdict fields only change on entry to a
  // terminal state and otherwise hold.
  always_comb begin
    state_d        = state_q;
    done_d         = done;
    pass_d         = pass;
    timeout_d      = timeout;
    fail_testnum_d = fail_testnum;
    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (end_req) begin
          state_d = S_CHECK;
        end else if (wd_hit) begin
          state_d        = S_TIMEOUT;
          done_d         = 1'b1;
          timeout_d      = 1'b1;
          fail_testnum_d = x3_nxt;
        end
      end
      S_CHECK: begin
        if (x27_nxt == ONE) begin
          state_d        = S_PASS;
          done_d         = 1'b1;
          pass_d         = 1'b1;
          fail_testnum_d = '0;
        end else begin
          state_d        = S_FAIL;
          done_d         = 1'b1;
          fail_testnum_d = x3_nxt;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Registered verdict outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      done         <= done_d;
      pass         <= pass_d;
      timeout      <= timeout_d;
      fail_testnum <= fail_testnum_d;
    end
  end

  // Cycle counter: runs in RUN and CHECK, saturates, frozen elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (cnt_en && (cycle_cnt != CNT_MAX)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

`ifdef RISCV_TEST_MONITOR_RETIRE_EN
  // Retired-instruction counter: same gating and saturation as cycle_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (cnt_en && wb.retire && (retire_cnt != CNT_MAX)) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - scoreboard bench for riscv_test_monitor
module tb_riscv_test_monitor;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int TO     = 20;

`ifdef RISCV_TEST_MONITOR_RETIRE_EN
  localparam logic [31:0] RET6 = 32'd6;
`else
  localparam logic [31:0] RET6 = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              done, pass, timeout;
  logic [DATA_W-1:0] fail_testnum;
  logic [CNT_W-1:0]  cycle_cnt, retire_cnt;

  always #5 clk = ~clk;

  riscv_test_monitor_if #(.DATA_W(DATA_W)) wb ();

  riscv_test_monitor #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb.slave),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_testnum(fail_testnum),
    .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [31:0] tn;
    logic [31:0] cyc;
    logic [31:0] ret;
    int          done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_no  = 0;
  int   e0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d, input logic r);
    wb.wb_we   = we;
    wb.wb_addr = a;
    wb.wb_data = d;
    wb.retire  = r;
    @(negedge clk);
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    wb.wb_we   = 1'b0;
    wb.wb_addr = 5'd0;
    wb.wb_data = '0;
    wb.retire  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [31:0] tn,
                          input logic [31:0] cyc, input logic [31:0] ret, input int de);
    exp_t e;
    e.pass = p; e.timeout = t; e.tn = tn; e.cyc = cyc; e.ret = ret; e.done_edge = de;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag, input int budget);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step(1'b0, 5'd0, 32'd0, 1'b0);
      n++;
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_done_edge"}, edge_no, e.done_edge);
    check_eq({tag, "_pass"}, pass, e.pass);
    check_eq({tag, "_timeout"}, timeout, e.timeout);
    check_eq({tag, "_fail_testnum"}, fail_testnum, e.tn);
    check_eq({tag, "_cycle_cnt"}, cycle_cnt, e.cyc);
    check_eq({tag, "_retire_cnt"}, retire_cnt, e.ret);
  endtask

  initial begin
    wb.wb_we = 1'b0; wb.wb_addr = 5'd0; wb.wb_data = '0; wb.retire = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_fail_testnum", fail_testnum, 0);
    check_eq("rst_cycle_cnt", cycle_cnt, 0);
    check_eq("rst_retire_cnt", retire_cnt, 0);

    // Pass with filtering, retire counting and stickiness.
    do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b1);          // IDLE edge, retire not counted
    e0 = edge_no;
    step(1'b1, 5'd3, 32'd5, 1'b1);          // RUN 1
    step(1'b1, 5'd27, 32'd1, 1'b1);         // RUN 2
    step(1'b1, 5'd0, 32'd1, 1'b1);          // RUN 3, x0 ignored
    step(1'b1, 5'd26, 32'd2, 1'b1);         // RUN 4, x26=2 shadow only
    step(1'b0, 5'd0, 32'd0, 1'b1);          // RUN 5
    step(1'b1, 5'd5, 32'd1, 1'b1);          // RUN 6, unrelated reg
    idle(3);                                // RUN 7..9
    check_eq("filter_no_end", done, 0);
    check_eq("run_cycle_cnt", cycle_cnt, 9);
    push_exp(1'b1, 1'b0, 32'd0, 32'd11, RET6, e0 + 11);
    step(1'b1, 5'd26, 32'd1, 1'b0);         // RUN 10
    check_eq("pass_latency_done0", done, 0);
    collect("pass", 4);
    step(1'b1, 5'd27, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd26, 32'd1, 1'b1);
    check_eq("sticky_pass", pass, 1);
    check_eq("sticky_done", done, 1);
    check_eq("sticky_cycle_cnt", cycle_cnt, 11);
    check_eq("sticky_retire_cnt", retire_cnt, RET6);
    check_eq("sticky_fail_testnum", fail_testnum, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("async_clr_done", done, 0);
    check_eq("async_clr_pass", pass, 0);
    check_eq("async_clr_cycle_cnt", cycle_cnt, 0);
    check_eq("async_clr_retire_cnt", retire_cnt, 0);

    // Plain fail.
    do_reset();
    idle(1);
    step(1'b1, 5'd3, 32'd7, 1'b0);
    step(1'b1, 5'd27, 32'd0, 1'b0);
    push_exp(1'b0, 1'b0, 32'd7, 32'd4, 32'd0, edge_no + 2);
    step(1'b1, 5'd26, 32'd1, 1'b0);
    collect("fail", 4);

    // Trailing x27=1 on the CHECK edge passes.
    do_reset();
    idle(1);
    step(1'b1, 5'd3, 32'd9, 1'b0);
    step(1'b1, 5'd27, 32'd0, 1'b0);
    push_exp(1'b1, 1'b0, 32'd0, 32'd4, 32'd0, edge_no + 2);
    step(1'b1, 5'd26, 32'd1, 1'b0);
    step(1'b1, 5'd27, 32'd1, 1'b0);
    collect("trail_pass", 4);

    // Trailing x27=0 on the CHECK edge fails.
    do_reset();
    idle(1);
    step(1'b1, 5'd3, 32'd4, 1'b0);
    step(1'b1, 5'd27, 32'd1, 1'b0);
    push_exp(1'b0, 1'b0, 32'd4, 32'd4, 32'd0, edge_no + 2);
    step(1'b1, 5'd26, 32'd1, 1'b0);
    step(1'b1, 5'd27, 32'd0, 1'b0);
    collect("trail_fail", 4);

    // x3 written on the FAIL entry edge is the one latched.
    do_reset();
    idle(1);
    step(1'b1, 5'd3, 32'd4, 1'b0);
    step(1'b1, 5'd27, 32'd0, 1'b0);
    push_exp(1'b0, 1'b0, 32'h55, 32'd4, 32'd0, edge_no + 2);
    step(1'b1, 5'd26, 32'd1, 1'b0);
    step(1'b1, 5'd3, 32'h55, 1'b0);
    collect("trail_x3", 4);

    // Mid-RUN asynchronous reset.
    do_reset();
    idle(1);
    step(1'b1, 5'd3, 32'd8, 1'b0);
    idle(2);
    check_eq("midrun_cycle_cnt", cycle_cnt, 3);
    #2 rst = 1'b0;
    #1;
    check_eq("midrun_clr_cycle_cnt", cycle_cnt, 0);
    check_eq("midrun_clr_done", done, 0);

    // Watchdog expiry.
    do_reset();
    idle(1);
    e0 = edge_no;
    step(1'b1, 5'd3, 32'd3, 1'b0);
    push_exp(1'b0, 1'b1, 32'd3, 32'd20, 32'd0, e0 + TO);
    collect("watchdog", 40);

    // x26=1 on the watchdog edge: CHECK path wins.
    do_reset();
    idle(1);
    e0 = edge_no;
    step(1'b1, 5'd3, 32'd3, 1'b0);
    step(1'b1, 5'd27, 32'd1, 1'b0);
    idle(TO - 3);
    push_exp(1'b1, 1'b0, 32'd0, 32'd21, 32'd0, e0 + TO + 1);
    step(1'b1, 5'd26, 32'd1, 1'b0);
    collect("wd_tie", 4);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable end-of-test monitor placed directly downstream of the register-file write-back port inside the soc.
- Snoops write-back traffic and keeps shadow copies of x3 (test number), x26 (test-end flag) and x27 (pass flag).
- Decides pass, fail or timeout, then freezes the verdict so the bench, or a future UART/LED reporter, can read it without hierarchical references into regs.

Parameters:
- DATA_W, 32, width of register data, the shadows and fail_testnum.
- TIMEOUT_CYCLES, 100000, watchdog limit in clk cycles counted in RUN; 0 disables the watchdog.
- CNT_W, 32, width of cycle_cnt (and retire_cnt when enabled).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; the monitor is held in reset while rst=0.
- wb_we  in  1  register-file write enable (one write per cycle maximum).
- wb_addr  in  5  destination register index.
- wb_data  in  DATA_W  write data.
- retire  in  1  one-cycle pulse per retired instruction (used only with the optional feature).
- done  out  1  verdict valid; sticky.
- pass  out  1  1 = test passed; valid when done=1.
- timeout  out  1  1 = watchdog expired.
- fail_testnum  out  DATA_W  x3 value latched on FAIL or TIMEOUT; 0 on PASS.
- cycle_cnt  out  CNT_W  cycles spent in RUN and CHECK.
- retire_cnt  out  CNT_W  retired instruction count; tied to 0 when the feature is disabled.

Behaviour:
- Reset, asynchronous with rst=0:
  - All shadows are 0.
  - State = IDLE.
  - done, pass, timeout, fail_testnum, cycle_cnt and retire_cnt are all 0.
  - Reset asserted mid-test aborts immediately; there is no residual state.
- Shadow update:
  - On a clk edge with wb_we=1 and wb_addr in {3, 26, 27}, the matching shadow takes wb_data.
  - wb_addr=0 and all other indices are ignored.
- FSM states:
  - IDLE to RUN on the first clk edge after rst deasserts; there is exactly one IDLE cycle.
  - RUN, on each edge:
    - cycle_cnt increments.
    - If this edge writes x26 with wb_data==1, go to CHECK.
    - Otherwise, if TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1, go to TIMEOUT.
    - A x26 write and watchdog expiry on the same edge: the x26 write wins, and the state goes to CHECK.
    - A x26 write with any value other than 1 updates the shadow only.
  - CHECK lasts one cycle and lets a trailing x27 write land:
    - cycle_cnt increments.
    - At the next edge, the x27 shadow is evaluated including any x27 write on that same edge.
    - x27==1 goes to PASS; any other value goes to FAIL.
  - PASS: done=1, pass=1, timeout=0, fail_testnum=0.
  - FAIL: done=1, pass=0, timeout=0, fail_testnum = x3 shadow including any x3 write on the entry edge.
  - TIMEOUT: done=1, pass=0, timeout=1, fail_testnum = x3 shadow.
  - PASS, FAIL and TIMEOUT are terminal and sticky until reset:
    - cycle_cnt and retire_cnt freeze.
    - Shadows keep updating.
    - Outputs do not change.
- Latency:
  - Write of x26=1 at edge N gives done=1 after edge N+1; outputs are registered.
- Counters:
  - Unsigned.
  - Saturate at all-ones; no wrap.

Optional Feature:
- Macro: RISCV_TEST_MONITOR_RETIRE_EN.
- Defined:
  - retire_cnt increments on each edge with retire=1 while in RUN or CHECK.
  - It saturates and freezes in terminal states, like cycle_cnt.
- Undefined:
  - retire_cnt is constant 0.
  - retire is ignored, with no logic generated for it.

Test Plan:
- Pass: reset, then write x3=5, x27=1, then x26=1 at cycle 10 -> done=1 and pass=1 one cycle later, fail_testnum=0, cycle_cnt=11.
- Fail: write x3=7, x27=0, x26=1 -> done=1, pass=0, timeout=0, fail_testnum=7.
- Trailing x27: write x26=1 at edge N, then x27=1 at edge N+1 -> PASS; same sequence with x27=0 at N+1 -> FAIL.
- Watchdog: TIMEOUT_CYCLES=20, x3=3, no x26 write -> timeout=1, done=1, fail_testnum=3, cycle_cnt=20. With x26=1 written on that same edge -> CHECK path wins, timeout stays 0.
- Filtering and stickiness:
  - Writes to x0 and x26=2 do not end the test.
  - After PASS, a further x27=0 write leaves pass=1 and cycle_cnt frozen.
  - Asserting rst=0 mid-RUN clears every output asynchronously, before the next clk edge.
- Feature on: 6 retire pulses before x26=1 -> retire_cnt=6 and frozen after done. Feature off: retire_cnt stays 0.
